// File: rtl/ife_win3x3_pkg.sv
// Shared types and constants for the ife_win3x3 3x3 window filter engine.
package ife_pkg;

  typedef enum logic [2:0] {
    MODE_MEAN   = 3'd0,
    MODE_MEDIAN = 3'd1,
    MODE_MAX    = 3'd2,
    MODE_MIN    = 3'd3,
    MODE_THRESH = 3'd4,
    MODE_PASS   = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CALC,
    ST_WRITE
  } state_e;

  localparam int N_TAPS     = 9;
  localparam int CENTRE_TAP = 4;
  localparam int LAST_K     = 9;

  // Row-major tap offsets, tap 0 = (-1,-1) ... tap 8 = (+1,+1)
  localparam int TAP_DR [N_TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [N_TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  localparam int PAD_VAL = 0;

endpackage

// File: rtl/ife_win3x3_if.sv
// Host-side bus of ife_win3x3: frame control, image ROM read port, result RAM write port.
interface ife_win3x3_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
);
  logic              ready;
  logic [2:0]        sel;
  logic              busy;
  logic [ADDR_W-1:0] iaddr;
  logic [PIX_W-1:0]  idata;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  data_wr;
  logic              wen;

  modport master (
    input  ready, sel, idata,
    output busy, iaddr, addr, data_wr, wen
  );

  modport slave (
    output ready, sel, idata,
    input  busy, iaddr, addr, data_wr, wen
  );
endinterface

// File: rtl/ife_win3x3_sort9.sv
// ife_sort9: 9-entry descending insertion array, one insert per cycle (built only with IFE_MEDIAN_EN).
module ife_sort9
  import ife_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_insert,
  input  logic [PIX_W-1:0] i_din,
  output logic [PIX_W-1:0] o_sorted [N_TAPS]
);

  logic [PIX_W-1:0]  r_s   [N_TAPS];
  logic [PIX_W-1:0]  w_nxt [N_TAPS];
  logic [N_TAPS-1:0] w_gt;

  // Strict compare so equal values land behind existing entries; cleared zeros act as pads.
  always_comb begin
    for (int i = 0; i < N_TAPS; i++) w_gt[i] = (r_s[i] < i_din);
    w_nxt[0] = w_gt[0] ? i_din : r_s[0];
    for (int i = 1; i < N_TAPS; i++)
      w_nxt[i] = !w_gt[i] ? r_s[i] : (w_gt[i-1] ? r_s[i-1] : i_din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s <= '{default: '0};
    end else if (i_clear) begin
      r_s <= '{default: '0};
    end else if (i_insert) begin
      r_s <= w_nxt;
    end
  end

  assign o_sorted = r_s;

endmodule

// File: rtl/ife_win3x3.sv
// ife_win3x3: raster-order 3x3 window filter, 12 cycles per pixel, zero-padded borders.
// Define IFE_MEDIAN_EN to build the full sorter (median mode); otherwise running max/min only.
module ife_win3x3
  import ife_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14,
  parameter int THRESH = 127
) (
  input logic          clk,
  input logic          reset,
  ife_win3x3_if.master bus
);

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [PIX_W+3:0]  DIV9     = (PIX_W + 4)'(9);
  localparam logic [PIX_W-1:0]  PAD      = PIX_W'(PAD_VAL);
  localparam logic [PIX_W-1:0]  THR      = PIX_W'(THRESH);

  state_e            r_state, w_state_nxt;
  logic [3:0]        r_k, w_nk, w_ktap, w_kcap;
  logic [ADDR_W-1:0] r_row, r_col, r_rbase;
  logic [ADDR_W-1:0] w_nrow, w_ncol, w_nrbase, w_taddr;
  logic [2:0]        r_mode;
  logic [PIX_W+3:0]  r_sum;
  logic [PIX_W-1:0]  r_centre, w_pix, w_result;
  logic              w_issue, w_capture, w_last_pix;
  logic              r_busy, r_wen;
  logic [ADDR_W-1:0] r_iaddr, r_addr;
  logic [PIX_W-1:0]  r_data_wr;

  function automatic logic tap_in(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col,
                                  input logic [3:0] k);
    int  dr = TAP_DR[k];
    int  dc = TAP_DC[k];
    logic ok = 1'b1;
    if (dr < 0 && row == '0)       ok = 1'b0;
    if (dr > 0 && row == ROW_LAST) ok = 1'b0;
    if (dc < 0 && col == '0)       ok = 1'b0;
    if (dc > 0 && col == COL_LAST) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] rbase,
                                                 input logic [ADDR_W-1:0] col,
                                                 input logic [3:0] k);
    logic [ADDR_W-1:0] a = rbase + col;
    if (TAP_DR[k] < 0) a = a - W_A;
    if (TAP_DR[k] > 0) a = a + W_A;
    if (TAP_DC[k] < 0) a = a - ONE_A;
    if (TAP_DC[k] > 0) a = a + ONE_A;
    return a;
  endfunction

  assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.ready) w_state_nxt = ST_FETCH;
      ST_FETCH: if (r_k == 4'(LAST_K)) w_state_nxt = ST_CALC;
      ST_CALC:  w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = w_last_pix ? ST_IDLE : ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Coordinates and tap index for the coming cycle, so iaddr is registered one cycle ahead of idata.
  always_comb begin
    w_nrow   = r_row;
    w_ncol   = r_col;
    w_nrbase = r_rbase;
    w_nk     = r_k + 4'd1;
    case (r_state)
      ST_IDLE: begin
        w_nrow   = '0;
        w_ncol   = '0;
        w_nrbase = '0;
        w_nk     = '0;
      end
      ST_WRITE: begin
        w_nk = '0;
        if (r_col == COL_LAST) begin
          w_ncol   = '0;
          w_nrow   = r_row + ONE_A;
          w_nrbase = r_rbase + W_A;
        end else begin
          w_ncol = r_col + ONE_A;
        end
      end
      default: ;
    endcase
    w_ktap  = (w_nk > 4'd8) ? 4'd0 : w_nk;
    w_issue = (w_state_nxt == ST_FETCH) && (w_nk <= 4'd8) && tap_in(w_nrow, w_ncol, w_ktap);
    w_taddr = tap_addr(w_nrbase, w_ncol, w_ktap);
  end

  assign w_capture = (r_state == ST_FETCH) && (r_k != 4'd0);
  assign w_kcap    = w_capture ? (r_k - 4'd1) : 4'd0;
  assign w_pix     = tap_in(r_row, r_col, w_kcap) ? bus.idata : PAD;

`ifdef IFE_MEDIAN_EN
  logic [PIX_W-1:0] w_sorted [N_TAPS];

  ife_sort9 #(.PIX_W(PIX_W)) u_sort (
    .clk      (clk),
    .rst      (reset),
    .i_clear  (r_state == ST_WRITE),
    .i_insert (w_capture),
    .i_din    (w_pix),
    .o_sorted (w_sorted)
  );

  wire [PIX_W-1:0] w_med = w_sorted[4];
  wire [PIX_W-1:0] w_max = w_sorted[0];
  wire [PIX_W-1:0] w_min = w_sorted[8];
`else
  logic [PIX_W-1:0] r_max, r_min;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max <= '0;
      r_min <= '1;
    end else if (r_state == ST_WRITE) begin
      r_max <= '0;
      r_min <= '1;
    end else if (w_capture) begin
      if (w_pix > r_max) r_max <= w_pix;
      if (w_pix < r_min) r_min <= w_pix;
    end
  end

  wire [PIX_W-1:0] w_med = '0;
  wire [PIX_W-1:0] w_max = r_max;
  wire [PIX_W-1:0] w_min = r_min;
`endif

  always_comb begin
    w_result = '0;
    case (r_mode)
      MODE_MEAN:   w_result = PIX_W'(r_sum / DIV9);
      MODE_MEDIAN: w_result = w_med;
      MODE_MAX:    w_result = w_max;
      MODE_MIN:    w_result = w_min;
      MODE_THRESH: w_result = (r_centre < THR) ? '0 : r_centre;
      MODE_PASS:   w_result = r_centre;
      default:     w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_rbase   <= '0;
      r_mode    <= '0;
      r_sum     <= '0;
      r_centre  <= '0;
      r_busy    <= 1'b0;
      r_iaddr   <= '0;
      r_addr    <= '0;
      r_data_wr <= '0;
      r_wen     <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_k       <= (w_state_nxt == ST_FETCH) ? w_nk : 4'd0;
      r_row     <= w_nrow;
      r_col     <= w_ncol;
      r_rbase   <= w_nrbase;
      r_wen     <= (r_state == ST_CALC);
      r_data_wr <= (r_state == ST_CALC) ? w_result : '0;
      if (w_issue) r_iaddr <= w_taddr;
      if (r_state == ST_IDLE && bus.ready) r_mode <= bus.sel;
      if (r_state == ST_CALC) r_addr <= r_rbase + r_col;
      if (r_state == ST_WRITE)  r_sum <= '0;
      else if (w_capture)       r_sum <= r_sum + {4'b0000, w_pix};
      if (w_capture && r_k == 4'(CENTRE_TAP + 1)) r_centre <= w_pix;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.iaddr   = r_iaddr;
  assign bus.addr    = r_addr;
  assign bus.data_wr = r_data_wr;
  assign bus.wen     = r_wen;

endmodule

// File: tb/tb_ife_win3x3.sv
// Directed bench for ife_win3x3 on a 4x4 image, checked against a window-level reference model.
module tb_ife_win3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int PW = 8;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ife_win3x3_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

  ife_win3x3 #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .THRESH(127)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int rom     [N];
  int exp_pix [N];
  int got     [N];
  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int bcyc    = 0;

  // Synchronous ROM: data valid the cycle after the address
  always @(posedge clk) bus.idata <= PW'(rom[int'(bus.iaddr) % N]);

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int model_pix(input int mode, input int r, input int c);
    int v [9];
    int n = 0;
    int s = 0;
    int centre;
    int t;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) v[n] = rom[(r + dr) * W + c + dc];
        else v[n] = 0;
        s += v[n];
        n++;
      end
    centre = v[4];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    case (mode)
      0: return s / 9;
`ifdef IFE_MEDIAN_EN
      1: return v[4];
`else
      1: return 0;
`endif
      2: return v[0];
      3: return v[8];
      4: return (centre < 127) ? 0 : centre;
      5: return centre;
      default: return 0;
    endcase
  endfunction

  // Cycle-level monitor: wen only in the 12th cycle of each pixel slot, at the slot's pixel address.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        check("wen_phase", int'(bus.wen), int'(bcyc % 12 == 11));
        if (bus.wen && bcyc / 12 < N) begin
          check("wr_addr", int'(bus.addr), bcyc / 12);
          check("wr_data", int'(bus.data_wr), exp_pix[bcyc / 12]);
          got[bcyc / 12] = int'(bus.data_wr);
          wr_cnt++;
        end else if (!bus.wen) begin
          check("data_off", int'(bus.data_wr), 0);
        end
        bcyc++;
      end else begin
        check("wen_idle", int'(bus.wen), 0);
        check("data_idle", int'(bus.data_wr), 0);
        bcyc = 0;
      end
    end
  end

  task automatic prep(input int mode);
    for (int i = 0; i < N; i++) begin
      exp_pix[i] = model_pix(mode, i / W, i % W);
      got[i] = -1;
    end
    wr_cnt = 0;
  endtask

  task automatic start(input int mode);
    @(negedge clk);
    bus.sel   = 3'(mode);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  task automatic run_frame(input int mode, input bit disturb);
    int n = 0;
    prep(mode);
    start(mode);
    while (bus.busy && n < 1000) begin
      if (disturb) begin
        if (n == 40) begin bus.sel = ~bus.sel; bus.ready = 1'b1; end
        if (n == 41) bus.ready = 1'b0;
        if (n == 100) bus.sel = 3'd7;
      end
      @(negedge clk);
      n++;
    end
    check("busy_cycles", n, 192);
    check("wen_count", wr_cnt, 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.ready = 1'b0;
    bus.sel   = 3'd0;
    for (int i = 0; i < N; i++) rom[i] = 0;
    #12;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_iaddr", int'(bus.iaddr), 0);
    check("rst_addr", int'(bus.addr), 0);
    check("rst_data", int'(bus.data_wr), 0);
    check("rst_wen", int'(bus.wen), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mean on a uniform image
    for (int i = 0; i < N; i++) rom[i] = 90;
    run_frame(0, 1'b0);
    check("mean_p0", got[0], 40);
    check("mean_p1", got[1], 60);
    check("mean_p5", got[5], 90);

    // Median on a ramp, with sel/ready disturbed mid-frame
    for (int i = 0; i < N; i++) rom[i] = i * 10;
    run_frame(1, 1'b1);
`ifdef IFE_MEDIAN_EN
    check("med_p5", got[5], 50);
`else
    check("med_p5", got[5], 0);
`endif
    check("med_p0", got[0], 0);
    run_frame(2, 1'b0);
    check("ramp_max_p5", got[5], 100);
    run_frame(6, 1'b0);
    check("mode6_p9", got[9], 0);

    // Single spike for max/min
    for (int i = 0; i < N; i++) rom[i] = 10;
    rom[5] = 200;
    run_frame(2, 1'b0);
    check("max_p0", got[0], 200);
    check("max_p15", got[15], 10);
    run_frame(3, 1'b0);
    check("min_p5", got[5], 10);
    check("min_p0", got[0], 0);

    // Threshold boundary and passthrough
    for (int i = 0; i < N; i++) rom[i] = 120 + i;
    run_frame(4, 1'b0);
    check("thr_126", got[6], 0);
    check("thr_127", got[7], 127);
    run_frame(5, 1'b0);
    check("pass_p3", got[3], 123);
    check("pass_p15", got[15], 135);

    // Reset mid-frame at pixel 7, then a clean restart
    prep(5);
    start(5);
    n = 0;
    while (wr_cnt < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_pix7", wr_cnt, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_wen", int'(bus.wen), 0);
    check("abort_iaddr", int'(bus.iaddr), 0);
    check("abort_data", int'(bus.data_wr), 0);
    repeat (3) @(negedge clk);
    check("abort_no_wr", wr_cnt, 7);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) rom[i] = 255 - i * 7;
    run_frame(5, 1'b0);
    check("restart_p0", got[0], 255);
    check("restart_p15", got[15], 150);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ife_win3x3.md
# ife_win3x3

Parametrised 3×3 window image filter engine for the final-project image pipeline. It is the successor to the fixed 128×128, 8-bit filter. The block reads a greyscale image from the host image ROM in raster order and applies one of six window operations per pixel: mean, median, max, min, centre threshold or passthrough. It writes one result per pixel to the result RAM. Image size, pixel width, address width and threshold are parameters, and out-of-image window taps are zero-padded.

## Interface
Parameters:
- IMG_W, 128, image width in pixels (≥2)
- IMG_H, 128, image height in pixels (≥2)
- PIX_W, 8, pixel width in bits
- ADDR_W, 14, address width; 2^ADDR_W ≥ IMG_W·IMG_H
- THRESH, 127, threshold for mode 4

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ready  in  1  frame start request, sampled in IDLE only
- sel  in  3  mode, latched on frame start
- busy  out  1  frame in progress
- iaddr  out  ADDR_W  image ROM read address
- idata  in  PIX_W  image ROM data, valid the cycle after iaddr
- addr  out  ADDR_W  result write address
- data_wr  out  PIX_W  result write data
- wen  out  1  result write strobe, one cycle per pixel

## Operation
- Modes (sel): 0 mean = floor(sum9/9); 1 median = 5th largest; 2 max; 3 min; 4 threshold = centre<THRESH ? 0 : centre; 5 passthrough = centre; 6–7 produce 0.
- Window tap order k=0..8 is row-major, with offsets (-1,-1) through (+1,+1). Tap 4 is the centre.
- A tap outside the image is replaced by 0. No new read is issued for it, and iaddr holds its previous value.
- Addresses are row·IMG_W+col. Row and column are tracked by counters plus a running row base. No divide or modulo is used.
- FSM states:
  - IDLE: busy=0. On ready=1, latch sel, clear row/col and go to FETCH.
  - FETCH: 10 cycles, k=0..9. Cycles 0–8 present tap k on iaddr. Cycles 1–9 capture tap k-1 (idata or pad) into the sorter and sum accumulator.
  - CALC: 1 cycle. Register the mode result. The divide-by-9 is constant, registered here.
  - WRITE: 1 cycle. Assert wen with addr=pixel index and data_wr=result. Clear the sorter and sum. Advance col, wrapping to 0 and incrementing row at IMG_W-1. Go to FETCH, or to IDLE after pixel IMG_W·IMG_H-1.
- Sum accumulator width is PIX_W+4 and cannot overflow.
- The sorter is a 9-entry descending insertion array with one insert per cycle. Equal values insert behind existing entries.
- ready while busy is ignored. sel changes mid-frame are ignored.

## Timing
- All outputs are registered. Reset values: busy=0, iaddr=0, addr=0, data_wr=0, wen=0. The FSM resets to IDLE and the counters to 0.
- Each pixel takes exactly 12 cycles.
- ready is sampled high at edge E0. busy rises after E0.
- The first wen is high in the cycle after edge E11.
- busy falls at edge E(12·IMG_W·IMG_H). It is high for exactly 12·N cycles.
- wen and data_wr are 0 outside WRITE.
- A reset asserted mid-frame aborts immediately: all outputs go to reset values, nothing further is written, and a new ready restarts from pixel 0.
- ready held high continuously restarts a new frame on the cycle after busy falls.

## Configuration
- IFE_MEDIAN_EN defined: the full 9-entry insertion sorter is built, and modes 1/2/3 read entries 4/0/8.
- IFE_MEDIAN_EN undefined: the sorter is replaced by running max and min registers. Mode 1 outputs 0. Modes 2/3 and all cycle timing are unchanged.

## Structure
- Package ife_pkg holds:
  - the mode enum (MODE_MEAN … MODE_PASS)
  - the FSM state enum
  - the tap row/column offset constants
  - the pad value constant
- Sub-module ife_sort9:
  - ports: clear, insert, data in, nine sorted outputs
  - parametrised by PIX_W
  - instantiated only under IFE_MEDIAN_EN
- Top-level holds the FSM, counters, address generation, accumulator and output registers.

## Test plan
- Use IMG_W=IMG_H=4 for all scenarios. ROM values are stated per scenario.
- Mean on uniform image: all pixels 90, sel=0 → pixel 0 = 40, pixel 1 = 60, pixel 5 = 90; exactly 16 wen pulses; busy high exactly 192 cycles.
- Median on ramp: idata = addr·10, sel=1 → pixel 5 = 50 (window 0,10,20,40,50,60,80,90,100); pixel 0 = 0 (five pads).
- Max/min: addr 5 = 200, others 10. sel=2 → pixel 0 = 200 and pixel 15 = 10. sel=3 → pixel 5 = 10 and pixel 0 = 0.
- Threshold: THRESH=127, centre 126 → 0, centre 127 → 127. sel=5 → output equals ROM image.
- Control robustness: toggle sel and pulse ready mid-frame → no effect. Assert reset at pixel 7 → wen=0 and busy=0 immediately; a restart produces 16 correct writes from addr 0.
- Build without IFE_MEDIAN_EN, ramp image: sel=1 → all outputs 0; sel=2 → pixel 5 = 100.
